// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter ownership and instruction fetch.
// The unit issues one word request at a time over req/gnt and waits for rvalid.
// Returned words go into a small FIFO. The FIFO head is registered and feeds
// decode over if_valid/if_ready.
// A taken redirect loads the resolved target, squashes the buffer and pulses
// flush_o on the following cycle.
// Optional feature macro: MISALIGN_TRAP_EN.
//   - Defined: a misaligned redirect target raises a one-cycle trap pulse and
//     parks fetch in HALT until the next aligned redirect.
//   - Undefined: the low two target bits are cleared and fetch carries on.
module pc_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_next_src,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            flush_o,
    output logic            misalign_trap_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // Fetch state
    logic [1:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_wait_pc;
    logic            r_discard;
    logic            r_flush;
    logic            r_trap;

    // Instruction buffer
    logic [XLEN-1:0] r_mem_pc    [BUF_DEPTH];
    logic [31:0]     r_mem_instr [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic            r_if_valid;
    logic [31:0]     r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    // Combinational helpers
    logic            w_redir;
    logic            w_misalign;
    logic            w_take;
    logic            w_trap_redir;
    logic [XLEN-1:0] w_target;
    logic            w_req;
    logic            w_gnt;
    logic            w_inflight;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic            w_discard_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [XLEN-1:0] w_head_pc_nxt;
    logic [31:0]     w_head_instr_nxt;

    assign w_redir = redir_valid & pc_next_src;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (pc_target[1:0] != 2'b00);
    assign w_target   = pc_target;
`else
    assign w_misalign = 1'b0;
    assign w_target   = pc_target & ~XLEN'(3);
`endif

    assign w_take       = w_redir & ~w_misalign;
    assign w_trap_redir = w_redir & w_misalign;

    // Request only while the buffer still has room for the returning word.
    assign w_req = (r_state == ST_REQ) && (r_count < DEPTH_C);
    assign w_gnt = w_req & imem_gnt;

    // A response is still owed to us after this cycle.
    assign w_inflight = ((r_state == ST_WAIT) && !imem_rvalid) ||
                        ((r_state == ST_REQ)  && w_gnt) ||
                        ((r_state == ST_HALT) && r_discard && !imem_rvalid);

    assign w_push = (r_state == ST_WAIT) & imem_rvalid & ~r_discard & ~w_redir;
    assign w_pop  = r_if_valid & if_ready;

    // Next fetch state: sequential progress, overridden by a redirect.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_discard_nxt  = r_discard;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (w_gnt) begin
                    w_state_nxt    = ST_WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt   = ST_REQ;
                    w_discard_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_HALT: begin
                if (imem_rvalid) begin
                    w_discard_nxt = 1'b0;
                end else begin
                    w_discard_nxt = r_discard;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_take) begin
            // A still-owed response must be swallowed before the new request.
            w_fetch_pc_nxt = w_target;
            w_discard_nxt  = w_inflight;
            w_state_nxt    = w_inflight ? ST_WAIT : ST_REQ;
        end else if (w_trap_redir) begin
            w_discard_nxt = w_inflight;
            w_state_nxt   = ST_HALT;
        end else begin
            w_discard_nxt = w_discard_nxt;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_wait_pc  <= RESET_PC;
            r_discard  <= 1'b0;
            r_flush    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_flush    <= w_redir;
            r_trap     <= w_trap_redir;
            if (w_gnt) begin
                r_wait_pc <= r_fetch_pc;
            end else begin
                r_wait_pc <= r_wait_pc;
            end
        end
    end

    // Next buffer pointers/count and the entry that will sit at the head.
    always_comb begin
        w_rd_nxt         = r_rd_ptr;
        w_wr_nxt         = r_wr_ptr;
        w_count_nxt      = r_count;
        w_head_pc_nxt    = r_if_pc;
        w_head_instr_nxt = r_if_instr;
        if (w_redir) begin
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
            w_wr_nxt    = r_wr_ptr + PTR_W'(w_push);
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push && (r_wr_ptr == w_rd_nxt)) begin
                w_head_pc_nxt    = r_wait_pc;
                w_head_instr_nxt = imem_rdata;
            end else begin
                w_head_pc_nxt    = r_mem_pc[w_rd_nxt];
                w_head_instr_nxt = r_mem_instr[w_rd_nxt];
            end
        end
    end

    // Buffer storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= 32'h0000_0000;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_wait_pc;
                r_mem_instr[r_wr_ptr] <= imem_rdata;
            end else begin
                r_mem_pc[r_wr_ptr]    <= r_mem_pc[r_wr_ptr];
                r_mem_instr[r_wr_ptr] <= r_mem_instr[r_wr_ptr];
            end
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered head; the last values are held while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= 32'h0000_0000;
        end else begin
            r_if_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_if_pc    <= w_head_pc_nxt;
                r_if_instr <= w_head_instr_nxt;
            end else begin
                r_if_pc    <= r_if_pc;
                r_if_instr <= r_if_instr;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign flush_o   = r_flush;

`ifdef MISALIGN_TRAP_EN
    assign misalign_trap_o = r_trap;
`else
    assign misalign_trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// A per-cycle vector table drives the main instance with RESET_PC = 0.
// A short hand-written sequence exercises a second instance with
// RESET_PC = 32'hFFFF_FFFC to cover wrap-around of the fetch address.
// Instruction words are tagged as {8'hA5, addr[23:0]}, so each word shows
// which fetch address it came from.
module tb_pc_fetch_unit;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic        ns;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvl;
        logic [31:0] rda;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_trap;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst_n, pc_next_src, redir_valid, imem_gnt, imem_rvalid, if_ready;
    logic [31:0] pc_target, imem_rdata;
    logic        imem_req, if_valid, flush_o, misalign_trap_o;
    logic [31:0] imem_addr, if_instr, if_pc;

    // Wrap-around instance signals
    logic        rst2_n, gnt2, rvalid2, rdy2;
    logic [31:0] rdata2;
    logic        req2, vld2, flush2, trap2;
    logic [31:0] addr2, instr2, pc2;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .pc_next_src(pc_next_src), .redir_valid(redir_valid),
        .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush_o(flush_o), .misalign_trap_o(misalign_trap_o)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .pc_next_src(1'b0), .redir_valid(1'b0),
        .pc_target(32'h0000_0000), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .if_valid(vld2), .if_ready(rdy2), .if_instr(instr2), .if_pc(pc2),
        .flush_o(flush2), .misalign_trap_o(trap2)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic a_rst, input logic a_rv, input logic a_ns, input logic [31:0] a_tgt,
                       input logic a_gnt, input logic a_rvl, input logic [31:0] a_rda, input logic a_rdy,
                       input logic a_ereq, input logic [31:0] a_eaddr, input logic a_evld,
                       input logic [31:0] a_epc, input logic a_eflush, input logic a_etrap);
        vec_t v;
        v.rst_n = a_rst; v.rv = a_rv; v.ns = a_ns; v.tgt = a_tgt;
        v.gnt = a_gnt; v.rvl = a_rvl; v.rda = a_rda; v.rdy = a_rdy;
        v.e_req = a_ereq; v.e_addr = a_eaddr; v.e_vld = a_evld; v.e_pc = a_epc;
        v.e_flush = a_eflush; v.e_trap = a_etrap;
        vecs.push_back(v);
    endtask

    initial begin
        //   rst  rv   ns   tgt            gnt  rvl  rda            rdy | req  addr           vld  pc             flush trap
        // reset, then sequential fetch with an always-ready decode
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 0
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 1
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 2 IDLE
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 3
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 4
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h4,        1'b1,32'h0,        1'b0,1'b0); // 5
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h4,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 6
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h8,        1'b1,32'h4,        1'b0,1'b0); // 7
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h8,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 8
        // decode stalls: buffer fills, request drops, then drains oldest first
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0, 1'b1,32'hC,        1'b1,32'h8,        1'b0,1'b0); // 9
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'hC,        1'b0, 1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b0); // 10
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b0); // 11 full
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b0); // 12 stray gnt
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b1,32'h8,        1'b0,1'b0); // 13 pop
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h10,       1'b1,32'hC,        1'b0,1'b0); // 14
        // redirect in WAIT: stale response dropped
        add(1'b1,1'b1,1'b1,32'h100,      1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 15
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h10,       1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0); // 16
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h100,      1'b0,32'h0,        1'b0,1'b0); // 17
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100,      1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 18
        // resolver valid but not taken: no effect
        add(1'b1,1'b1,1'b0,32'h300,      1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h104,      1'b1,32'h100,      1'b0,1'b0); // 19
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h104,      1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 20
        // redirect with gnt in the same cycle
        add(1'b1,1'b1,1'b1,32'h40,       1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h108,      1'b1,32'h104,      1'b0,1'b0); // 21
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h108,      1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0); // 22
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h40,       1'b0,32'h0,        1'b0,1'b0); // 23 held
        // redirect in REQ without gnt: request withdrawn
        add(1'b1,1'b1,1'b1,32'h80,       1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h40,       1'b0,32'h0,        1'b0,1'b0); // 24
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h80,       1'b0,32'h0,        1'b1,1'b0); // 25
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h80,       1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 26
        // misaligned redirect target 0x102
        add(1'b1,1'b1,1'b1,32'h102,      1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h84,       1'b1,32'h80,       1'b0,1'b0); // 27
`ifdef MISALIGN_TRAP_EN
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b1); // 28 HALT
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100,      1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 29
        add(1'b1,1'b1,1'b1,32'h200,      1'b0,1'b0,32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 30
`else
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0, 1'b1,32'h100,      1'b0,32'h0,        1'b1,1'b0); // 28
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100,      1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 29
        add(1'b1,1'b1,1'b1,32'h200,      1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h104,      1'b1,32'h100,      1'b0,1'b0); // 30
`endif
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h200,      1'b0,32'h0,        1'b1,1'b0); // 31
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h200,      1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 32
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h204,      1'b1,32'h200,      1'b0,1'b0); // 33
        add(1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1, 1'b1,32'h204,      1'b0,32'h0,        1'b0,1'b0); // 34
        // reset mid-transaction, stale rvalid afterwards is ignored
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 35
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h204,      1'b1, 1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 36
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 37
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b0); // 38

        rst2_n = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdy2 = 1'b1; rdata2 = 32'h0;

        for (int k = 0; k < vecs.size(); k++) begin
            rst_n       = vecs[k].rst_n;
            redir_valid = vecs[k].rv;
            pc_next_src = vecs[k].ns;
            pc_target   = vecs[k].tgt;
            imem_gnt    = vecs[k].gnt;
            imem_rvalid = vecs[k].rvl;
            imem_rdata  = tag(vecs[k].rda);
            if_ready    = vecs[k].rdy;
            @(negedge clk);
            check($sformatf("v%0d req", k), {31'b0, imem_req}, {31'b0, vecs[k].e_req});
            if (vecs[k].e_req)
                check($sformatf("v%0d addr", k), imem_addr, vecs[k].e_addr);
            check($sformatf("v%0d if_valid", k), {31'b0, if_valid}, {31'b0, vecs[k].e_vld});
            if (vecs[k].e_vld) begin
                check($sformatf("v%0d if_pc", k), if_pc, vecs[k].e_pc);
                check($sformatf("v%0d if_instr", k), if_instr, tag(vecs[k].e_pc));
            end
            check($sformatf("v%0d flush", k), {31'b0, flush_o}, {31'b0, vecs[k].e_flush});
            check($sformatf("v%0d trap", k), {31'b0, misalign_trap_o}, {31'b0, vecs[k].e_trap});
            @(posedge clk); #1;
        end

        // Wrap-around instance: RESET_PC = 0xFFFF_FFFC
        check("wrap reset req", {31'b0, req2}, 32'd0);
        check("wrap reset vld", {31'b0, vld2}, 32'd0);
        rst2_n = 1'b1;
        begin : wait_req
            bit seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                @(negedge clk);
                if (req2) seen = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("wrap req within bound", {31'b0, seen}, 32'd1);
        end
        check("wrap first addr", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1;
        @(posedge clk); #1;
        gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = tag(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap wait req", {31'b0, req2}, 32'd0);
        @(posedge clk); #1;
        rvalid2 = 1'b0;
        @(negedge clk);
        check("wrap second req", {31'b0, req2}, 32'd1);
        check("wrap second addr", addr2, 32'h0000_0000);
        check("wrap head vld", {31'b0, vld2}, 32'd1);
        check("wrap head pc", pc2, 32'hFFFF_FFFC);
        check("wrap head instr", instr2, tag(32'hFFFF_FFFC));
        check("wrap flush", {31'b0, flush2}, 32'd0);
        check("wrap trap", {31'b0, trap2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
